// File: rtl/bounce_pkg.sv
// Shared types and pure helpers for the bounce motion sequencer: FSM states,
// playfield limit/reset derivation and the per-axis wall reflection.
package bounce_pkg;

    localparam int CW = 16;

    typedef logic [CW-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    typedef struct packed {
        coord_t pos;
        logic   dir;
        logic   hit;
    } axis_upd_t;

    function automatic int limit_of(input int max_v, input int size);
        return max_v + 1 - size;
    endfunction

    function automatic int reset_pos(input int max_v, input int size);
        return limit_of(max_v, size) / 2;
    endfunction

    function automatic axis_upd_t reflect(input coord_t p, input logic [2:0] s,
                                          input logic dir, input coord_t lim);
        axis_upd_t   r;
        coord_t      s_w;
        logic [CW:0] sum;
        s_w   = coord_t'(s);
        sum   = {1'b0, p} + {1'b0, s_w};
        r.pos = p;
        r.dir = dir;
        r.hit = 1'b0;
        if (s != 3'd0) begin
            if (dir) begin
                if (sum < {1'b0, lim}) begin
                    r.pos = coord_t'(sum);
                end else begin
                    // 2L-(p+s) also covers the exact-wall case, which lands on L.
                    r.pos = coord_t'({lim, 1'b0} - sum);
                    r.dir = 1'b0;
                    r.hit = 1'b1;
                end
            end else if (s_w < p) begin
                r.pos = p - s_w;
            end else begin
                r.pos = s_w - p;
                r.dir = 1'b1;
                r.hit = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// One motion axis: speed sample, reflected next-state holding register and the
// committed position/direction/hit registers; updates only on the FSM strobes.
module bounce_axis
    import bounce_pkg::*;
#(
    parameter int W       = 10,
    parameter int LIM     = 632,
    parameter int RST_POS = 316
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         launch,
    input  logic         calc,
    input  logic         commit,
    input  logic [2:0]   speed,
    output logic [W-1:0] pos,
    output logic         dir,
    output logic         hit
);

    localparam coord_t       LIM_C = coord_t'(LIM);
    localparam logic [W-1:0] LIM_W = LIM[W-1:0];
    localparam logic [W-1:0] RST_V = RST_POS[W-1:0];

    logic [2:0]   spd_q;
    axis_upd_t    res;
    logic [W-1:0] res_pos;
    logic [W-1:0] hold_pos;
    logic         hold_dir;
    logic         hold_hit;

    assign res = reflect(coord_t'(pos), spd_q, dir, LIM_C);

    // Saturate rather than wrap if W is ever set too narrow for the limit.
    assign res_pos = (|res.pos[CW-1:W]) ? LIM_W : res.pos[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_q    <= 3'd0;
            hold_pos <= RST_V;
            hold_dir <= 1'b1;
            hold_hit <= 1'b0;
            pos      <= RST_V;
            dir      <= 1'b1;
            hit      <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (launch) begin
                spd_q <= speed;
            end
            if (calc) begin
                hold_pos <= res_pos;
                hold_dir <= res.dir;
                hold_hit <= res.hit;
            end
            if (commit) begin
                pos <= hold_pos;
                dir <= hold_dir;
                hit <= hold_hit;
            end
        end
    end

endmodule

// File: rtl/bounce_motion_ctrl.sv
// Frame-rate ball sequencer: IDLE->CALC->COMMIT per accepted tick, results visible
// two edges after the tick; ticks arriving while busy are dropped, never queued.
module bounce_motion_ctrl
    import bounce_pkg::*;
#(
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int BALL_SIZE = 8,
    parameter int W         = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         frame_tick,
    input  logic         run,
    input  logic         step,
    input  logic [2:0]   speed_x,
    input  logic [2:0]   speed_y,
    output logic [W-1:0] ball_x,
    output logic [W-1:0] ball_y,
    output logic         dir_x,
    output logic         dir_y,
    output logic         hit_x,
    output logic         hit_y,
    output logic         busy
);

    localparam int XLIM = limit_of(X_MAX, BALL_SIZE);
    localparam int YLIM = limit_of(Y_MAX, BALL_SIZE);
    localparam int XRST = reset_pos(X_MAX, BALL_SIZE);
    localparam int YRST = reset_pos(Y_MAX, BALL_SIZE);

    state_t state;
    state_t state_nxt;
    logic   step_q;
    logic   step_pend;
    logic   step_rise;
    logic   launch;
    logic   calc;
    logic   commit;

    assign step_rise = step & ~step_q;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= step;
            // Step edges latch even while disabled; a launch consumes any pending request.
            if (launch) begin
                step_pend <= 1'b0;
            end else if (step_rise) begin
                step_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        calc      = 1'b0;
        commit    = 1'b0;
        if (!ena) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick && (run || step_pend || step_rise)) begin
                        launch    = 1'b1;
                        state_nxt = ST_CALC;
                    end
                end
                ST_CALC: begin
                    calc      = 1'b1;
                    state_nxt = ST_COMMIT;
                end
                ST_COMMIT: begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    bounce_axis #(
        .W       (W),
        .LIM     (XLIM),
        .RST_POS (XRST)
    ) u_axis_x (
        .clk    (clk),
        .rst_n  (rst_n),
        .launch (launch),
        .calc   (calc),
        .commit (commit),
        .speed  (speed_x),
        .pos    (ball_x),
        .dir    (dir_x),
        .hit    (hit_x)
    );

    bounce_axis #(
        .W       (W),
        .LIM     (YLIM),
        .RST_POS (YRST)
    ) u_axis_y (
        .clk    (clk),
        .rst_n  (rst_n),
        .launch (launch),
        .calc   (calc),
        .commit (commit),
        .speed  (speed_y),
        .pos    (ball_y),
        .dir    (dir_y),
        .hit    (hit_y)
    );

endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// Bench for bounce_motion_ctrl: a default-size and a 40x40 playfield instance share
// stimulus and are checked against an unfolded-circle motion model.
module tb_bounce_motion_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       frame_tick;
    logic       run;
    logic       step;
    logic [2:0] speed_x;
    logic [2:0] speed_y;
    logic [9:0] bx[2];
    logic [9:0] by[2];
    logic       bdx[2];
    logic       bdy[2];
    logic       bhx[2];
    logic       bhy[2];
    logic       bbusy[2];

    int n_cmp;
    int n_fail;

    int lim[2][2]  = '{'{632, 472}, '{32, 32}};
    int rpos[2][2] = '{'{316, 236}, '{16, 16}};
    int m_pos[2][2];
    bit m_dir[2][2];
    bit m_hit[2][2];
    bit m_pend;
    bit last_upd;

    logic [52:0] obs[2];
    logic [52:0] exp_obs[2];
    logic        obs_hx[2];
    logic        obs_hy[2];

    bounce_motion_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .run(run), .step(step),
        .speed_x(speed_x), .speed_y(speed_y), .ball_x(bx[0]), .ball_y(by[0]),
        .dir_x(bdx[0]), .dir_y(bdy[0]), .hit_x(bhx[0]), .hit_y(bhy[0]), .busy(bbusy[0])
    );

    bounce_motion_ctrl #(.X_MAX(39), .Y_MAX(39), .BALL_SIZE(8), .W(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .run(run), .step(step),
        .speed_x(speed_x), .speed_y(speed_y), .ball_x(bx[1]), .ball_y(by[1]),
        .dir_x(bdx[1]), .dir_y(bdy[1]), .hit_x(bhx[1]), .hit_y(bhy[1]), .busy(bbusy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Model: motion unfolded onto a circle of circumference 2L; the first half is +dir.
    task automatic model_adv(input int sx, input int sy);
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 2; a++) begin
                int L, u, s;
                bit nd;
                L = lim[i][a];
                s = (a == 0) ? sx : sy;
                u = m_dir[i][a] ? m_pos[i][a] : 2 * L - m_pos[i][a];
                u = (u + s) % (2 * L);
                nd = (u < L);
                m_hit[i][a] = (nd != m_dir[i][a]);
                m_dir[i][a] = nd;
                m_pos[i][a] = (u <= L) ? u : 2 * L - u;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 2; a++) begin
                m_pos[i][a] = rpos[i][a];
                m_dir[i][a] = 1'b1;
                m_hit[i][a] = 1'b0;
            end
        end
        m_pend = 1'b0;
    endtask

    function automatic logic [23:0] mvec(input int i, input bit hits);
        return {10'(m_pos[i][0]), 10'(m_pos[i][1]), m_dir[i][0], m_dir[i][1],
                hits & m_hit[i][0], hits & m_hit[i][1]};
    endfunction

    function automatic logic [23:0] dvec(input int i);
        return {bx[i], by[i], bdx[i], bdy[i], bhx[i], bhy[i]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        step       = 1'b0;
        frame_tick = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_step(input bit v);
        @(negedge clk);
        if (v && !step) m_pend = 1'b1;
        step = v;
    endtask

    // One frame tick; captures busy over T+1..T+3, outputs at T+2 and T+3, hits at T+4.
    task automatic tick(input bit drop, input bit scramble);
        logic [2:0]  bz[2];
        logic [23:0] mid[2];
        logic [23:0] mid_exp[2];
        logic [23:0] fin[2];
        logic [1:0]  tl[2];
        int sx, sy;
        @(negedge clk);
        frame_tick = 1'b1;
        last_upd = ena && (run || m_pend);
        sx = int'(speed_x);
        sy = int'(speed_y);
        if (last_upd) m_pend = 1'b0;
        for (int i = 0; i < 2; i++) mid_exp[i] = mvec(i, 1'b0);
        @(negedge clk);
        frame_tick = drop && last_upd;
        if (scramble) begin
            speed_x = 3'($urandom_range(7));
            speed_y = 3'($urandom_range(7));
        end
        for (int i = 0; i < 2; i++) bz[i][2] = bbusy[i];
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bz[i][1] = bbusy[i];
            mid[i]   = dvec(i);
        end
        @(negedge clk);
        if (last_upd) begin
            model_adv(sx, sy);
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_hit[i][0] = 1'b0;
                m_hit[i][1] = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            bz[i][0]  = bbusy[i];
            fin[i]    = dvec(i);
            obs_hx[i] = bhx[i];
            obs_hy[i] = bhy[i];
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tl[i]      = {bhx[i], bhy[i]};
            obs[i]     = {bz[i], mid[i], fin[i], tl[i]};
            exp_obs[i] = {last_upd, last_upd, 1'b0, mid_exp[i], mvec(i, 1'b1), 2'b00};
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({dvec(i), bbusy[i]} !== {mvec(i, 1'b0), 1'b0}) begin
                n_fail++;
                $display("FAIL reset inst%0d: got %h want %h", i, {dvec(i), bbusy[i]}, {mvec(i, 1'b0), 1'b0});
            end
        end
        n_cmp++;
        if ({bx[0], by[0]} !== {10'd316, 10'd236}) begin
            n_fail++;
            $display("FAIL reset_pos_default: got %0d/%0d want 316/236", bx[0], by[0]);
        end
    endtask

    task automatic test_basic();
        run     = 1'b1;
        speed_x = 3'd3;
        speed_y = 3'd2;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== exp_obs[i]) begin
                n_fail++;
                $display("FAIL basic inst%0d: got %h want %h", i, obs[i], exp_obs[i]);
            end
        end
        n_cmp++;
        if ({bx[0], by[0]} !== {10'd319, 10'd238}) begin
            n_fail++;
            $display("FAIL basic_pos: got %0d/%0d want 319/238", bx[0], by[0]);
        end
    endtask

    task automatic test_overshoot();
        int exp_x[7] = '{23, 30, 27, 20, 13, 6, 1};
        do_reset();
        run     = 1'b1;
        speed_x = 3'd7;
        speed_y = 3'd0;
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, 1'b0);
            n_cmp++;
            if (obs[1] !== exp_obs[1]) begin
                n_fail++;
                $display("FAIL overshoot_model step%0d: got %h want %h", k, obs[1], exp_obs[1]);
            end
            n_cmp++;
            if ({bx[1], bdx[1], obs_hx[1]} !== {10'(exp_x[k]), (k < 2 || k == 6), (k == 2 || k == 6)}) begin
                n_fail++;
                $display("FAIL overshoot step%0d: got x=%0d dir=%b hit=%b want x=%0d", k, bx[1], bdx[1], obs_hx[1], exp_x[k]);
            end
        end
    endtask

    task automatic test_exact_wall();
        int exp_x[5] = '{20, 24, 28, 32, 28};
        do_reset();
        run     = 1'b1;
        speed_x = 3'd4;
        speed_y = 3'd1;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0);
            n_cmp++;
            if ({bx[1], bdx[1], obs_hx[1]} !== {10'(exp_x[k]), (k < 3), (k == 3)}) begin
                n_fail++;
                $display("FAIL exact_wall step%0d: got x=%0d dir=%b hit=%b want x=%0d", k, bx[1], bdx[1], obs_hx[1], exp_x[k]);
            end
        end
        n_cmp++;
        if (obs[0] !== exp_obs[0]) begin
            n_fail++;
            $display("FAIL exact_wall_a: got %h want %h", obs[0], exp_obs[0]);
        end
    endtask

    task automatic test_step();
        do_reset();
        run     = 1'b0;
        speed_x = 3'd2;
        speed_y = 3'd3;
        set_step(1'b1);
        set_step(1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_obs[i]) begin
                    n_fail++;
                    $display("FAIL step tick%0d inst%0d: got %h want %h", k, i, obs[i], exp_obs[i]);
                end
            end
        end
        n_cmp++;
        if ({bx[1], by[1]} !== {10'd18, 10'd19}) begin
            n_fail++;
            $display("FAIL step_once: got %0d/%0d want 18/19", bx[1], by[1]);
        end
        run     = 1'b1;
        speed_x = 3'd1;
        speed_y = 3'd1;
        tick(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({bx[1], by[1], bbusy[1]} !== {10'd19, 10'd20, 1'b0}) begin
            n_fail++;
            $display("FAIL tick_while_busy: got %0d/%0d busy=%b want 19/20 busy=0", bx[1], by[1], bbusy[1]);
        end
    endtask

    task automatic test_ena();
        ena     = 1'b0;
        run     = 1'b1;
        speed_x = 3'd5;
        speed_y = 3'd6;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0);
            n_cmp++;
            if ({obs[0], obs[1]} !== {exp_obs[0], exp_obs[1]}) begin
                n_fail++;
                $display("FAIL ena_low tick%0d: got %h/%h want %h/%h", k, obs[0], obs[1], exp_obs[0], exp_obs[1]);
            end
        end
        set_step(1'b1);
        set_step(1'b0);
        ena = 1'b1;
        run = 1'b0;
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({obs[0], obs[1]} !== {exp_obs[0], exp_obs[1]}) begin
            n_fail++;
            $display("FAIL ena_step_latched: got %h/%h want %h/%h", obs[0], obs[1], exp_obs[0], exp_obs[1]);
        end
        run = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        ena        = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({dvec(i), bbusy[i]} !== {mvec(i, 1'b0), 1'b0}) begin
                n_fail++;
                $display("FAIL ena_abandon inst%0d: got %h want %h", i, {dvec(i), bbusy[i]}, {mvec(i, 1'b0), 1'b0});
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_rst_mid();
        run     = 1'b1;
        speed_x = 3'd5;
        speed_y = 3'd5;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        n_cmp++;
        if (bbusy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got %b want 1", bbusy[1]);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({dvec(i), bbusy[i]} !== {mvec(i, 1'b0), 1'b0}) begin
                n_fail++;
                $display("FAIL rst_mid_now inst%0d: got %h want %h", i, {dvec(i), bbusy[i]}, {mvec(i, 1'b0), 1'b0});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dvec(1), bbusy[1]} !== {mvec(1, 1'b0), 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_no_commit: got %h want %h", {dvec(1), bbusy[1]}, {mvec(1, 1'b0), 1'b0});
        end
    endtask

    task automatic test_corner();
        do_reset();
        run     = 1'b1;
        speed_x = 3'd4;
        speed_y = 3'd4;
        repeat (4) tick(1'b0, 1'b0);
        n_cmp++;
        if ({bx[1], by[1], bdx[1], bdy[1], obs_hx[1], obs_hy[1]} !== {10'd32, 10'd32, 4'b0011}) begin
            n_fail++;
            $display("FAIL corner: got %0d/%0d dir=%b%b hit=%b%b want 32/32 dir=00 hit=11",
                     bx[1], by[1], bdx[1], bdy[1], obs_hx[1], obs_hy[1]);
        end
        n_cmp++;
        if (obs[1] !== exp_obs[1]) begin
            n_fail++;
            $display("FAIL corner_model: got %h want %h", obs[1], exp_obs[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 150; k++) begin
            ena     = ($urandom_range(7) != 0);
            run     = 1'($urandom_range(1));
            speed_x = 3'($urandom_range(7));
            speed_y = 3'($urandom_range(7));
            if ($urandom_range(3) == 0) begin
                set_step(1'b1);
                set_step(1'b0);
            end
            tick($urandom_range(3) == 0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_obs[i]) begin
                    n_fail++;
                    $display("FAIL random iter%0d inst%0d: got %h want %h", k, i, obs[i], exp_obs[i]);
                end
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        frame_tick = 1'b0;
        run        = 1'b0;
        step       = 1'b0;
        speed_x    = 3'd0;
        speed_y    = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_overshoot();
        test_exact_wall();
        test_step();
        test_ena();
        test_rst_mid();
        test_corner();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bounce_motion_ctrl.md
# bounce_motion_ctrl

Frame-rate motion sequencer for the `tt_um_bounce` top level. On each frame tick it advances the ball's X/Y position by the programmed per-axis speed and reflects the ball off the playfield walls. It reports the result to the pixel generator as an atomically updated coordinate pair plus wall-hit pulses. It sits between the `ui_in` control pins (run/step/speed) and the raster/render logic.

## Interface
- `X_MAX`, default 639: last visible column.
- `Y_MAX`, default 479: last visible row.
- `BALL_SIZE`, default 8: ball edge length in pixels. Derived limits: `XLIM = X_MAX+1-BALL_SIZE`, `YLIM = Y_MAX+1-BALL_SIZE`.
- `W`, default 10: coordinate width.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset. Asynchronous, active-low.
- `ena  in  1`: design selected; when low the block freezes.
- `frame_tick  in  1`: one-cycle pulse, once per frame at the start of vertical blank.
- `run  in  1`: level; continuous motion.
- `step  in  1`: level; each rising edge requests exactly one update.
- `speed_x  in  3`: X pixels per frame (0–7).
- `speed_y  in  3`: Y pixels per frame (0–7).
- `ball_x  out  W`: top-left X, range 0..XLIM.
- `ball_y  out  W`: top-left Y, range 0..YLIM.
- `dir_x  out  1`: 1 = moving +X.
- `dir_y  out  1`: 1 = moving +Y.
- `hit_x  out  1`: one-cycle pulse on a side-wall bounce.
- `hit_y  out  1`: one-cycle pulse on a top/bottom-wall bounce.
- `busy  out  1`: high while an update is in flight.

## Operation
- Reset values:
  - `ball_x = XLIM/2` (floor) and `ball_y = YLIM/2` (floor).
  - `dir_x = dir_y = 1`.
  - `hit_x = hit_y = busy = 0`.
  - `step_pend = 0`, `step` edge register = 0, FSM in IDLE.
- Step detect: a rising edge of `step` sets `step_pend`. `step_pend` clears when an update launches.
- FSM states: IDLE → CALC → COMMIT → IDLE.
  - IDLE: on `frame_tick & ena & (run | step_pend | step edge this cycle)`, sample `speed_x`/`speed_y`, clear `step_pend`, go to CALC.
  - CALC: compute the next position and direction for both axes into holding registers.
  - COMMIT: write `ball_x`, `ball_y`, `dir_x`, `dir_y` together; pulse `hit_x`/`hit_y` in this same cycle; return to IDLE.
- Per-axis arithmetic uses a W+1-bit sum; `s` = speed, `p` = position, `L` = limit.
  - Moving +, `p+s < L`: `p' = p+s`.
  - Moving +, `p+s == L`: `p' = L`, flip direction, hit.
  - Moving +, `p+s > L`: `p' = 2L-(p+s)`, flip, hit.
  - Moving −, `s < p`: `p' = p-s`.
  - Moving −, `s == p`: `p' = 0`, flip, hit.
  - Moving −, `s > p`: `p' = s-p`, flip, hit.
  - `s == 0`: position and direction hold, no hit.
  - Outputs never leave `0..L`, given `L ≥ 7`.
- Boundary rules:
  - A `frame_tick` while `busy` is dropped. No queuing.
  - `run` and a step request together produce one update; `step_pend` is still cleared.
  - A corner bounce flips both axes, and `hit_x` and `hit_y` pulse in the same cycle.
  - `ena` low: FSM forced to IDLE at the next edge (an in-flight update is abandoned), ticks ignored, outputs hold, `step` edges still latch.
  - `rst_n` asserted mid-update: all state returns to reset values immediately; no partial commit.

## Timing
- Latency: tick at cycle T → `busy` high T+1..T+2 → new coordinates and hit pulses visible from T+2's edge (readable in cycle T+3).
- `ball_x`/`ball_y` change only in COMMIT, never mid-frame from the renderer's view.
- `hit_x`/`hit_y` are exactly one cycle wide and only ever assert in COMMIT.
- Speeds are sampled once per update, in the IDLE→CALC cycle.

## Structure
- `bounce_pkg` holds:
  - the state enum (IDLE, CALC, COMMIT);
  - the reset-position and limit derivation functions;
  - the pure function `reflect(p, s, dir, L)` returning `{p', dir', hit}`.
- One sub-module, `bounce_axis`: position/direction/hit registers for one axis plus the `reflect` call. It is instantiated twice (X with XLIM, Y with YLIM) under the shared FSM in `bounce_motion_ctrl`.

## Test plan
- Reset, default params: `ball_x=316`, `ball_y=236`, `dir_x=dir_y=1`, `busy=0`. Then `run=1`, `speed_x=3`, `speed_y=2`, one tick → `ball_x=319`, `ball_y=238` exactly 3 cycles after the tick.
- Overshoot bounce (`X_MAX=39`, `BALL_SIZE=8`, so XLIM=32, start 16; `speed_x=7`, run): sequence 23, 30, then 27 with `dir_x=0` and a single `hit_x` pulse.
- Exact-wall bounce (same params, `speed_x=4`): 20, 24, 28, 32 with flip and `hit_x`, then 28. Continuing the previous scenario at speed 7 toward 0: 20, 13, 6, then 1 with `dir_x=1` and `hit_x`.
- Step mode (`run=0`): pulse `step` once, then issue 3 ticks → exactly one update. A tick arriving while `busy` is dropped: positions advance once, not twice.
- `ena` low for 5 ticks → no change. Assert `rst_n` in the CALC cycle → outputs at reset values immediately and no COMMIT follows.
- Corner (`X_MAX=Y_MAX=39`, speeds 4/4 from 16/16): fourth update gives 32/32, both dirs flipped, `hit_x` and `hit_y` in the same cycle.
